// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared states, widths and op-bit encoding for the SPI memory arbiter
package spi_mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;
  typedef enum logic [3:0] {
    IDLE, START, OPBIT, ADDR, WDATA, WAIT_RDY, RDATA, WAIT_DONE, ACK
  } state_t;
endpackage

// File: rtl/spi_mem_shifter.sv
// spi_mem_shifter: 8-bit LSB-first shift register with bit counter, shared by address, write and read phases
module spi_mem_shifter
  import spi_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              sin,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic              last
);
  logic [2:0] cnt;
  // load restarts the bit count; shift moves sin in at the top and the LSB out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      cnt <= '0;
    end else if (load) begin
      q <= din;
      cnt <= '0;
    end else if (shift) begin
      q <= {sin, q[DATA_W-1:1]};
      cnt <= cnt + 3'd1;
    end
  assign last = cnt == 3'd7;
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: two-requester round-robin arbiter driving a serial memory; SPI_MEM_ARB_TIMEOUT_EN adds a wait watchdog
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     cs_n,
  output logic                     sdo,
  input  logic                     sdi,
  input  logic                     mem_ready,
  input  logic                     mem_op_done
);
  state_t state, nxt;
  logic gnt, win, we_l, sload, sshift, slast, tmo_hit;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l, sdin, sq;

  // gnt doubles as "last granted", so reset to 1 gives requester 0 the first tie
  assign win = (req[0] & req[1]) ? ~gnt : req[1];

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = |req ? START : IDLE;
      START:     nxt = OPBIT;
      OPBIT:     nxt = ADDR;
      ADDR:      nxt = slast ? (we_l == OP_WR ? WDATA : WAIT_RDY) : ADDR;
      WDATA:     nxt = slast ? WAIT_DONE : WDATA;
      WAIT_RDY:  nxt = mem_ready ? RDATA : tmo_hit ? ACK : WAIT_RDY;
      RDATA:     nxt = slast ? WAIT_DONE : RDATA;
      WAIT_DONE: nxt = (mem_op_done || tmo_hit) ? ACK : WAIT_DONE;
      default:   nxt = IDLE;
    endcase
  end

  // capture the winner's request so the other requester is ignored until ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt <= 1'b1;
      we_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
    end else if (state == IDLE && |req) begin
      gnt <= win;
      we_l <= win ? we[1] : we[0];
      addr_l <= win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
      wdata_l <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end

  // address loads during OPBIT, write data on the last address bit, and a clear on read start
  assign sload = state == OPBIT || (state == ADDR && slast && we_l == OP_WR) ||
                 (state == WAIT_RDY && mem_ready);
  assign sdin = state == OPBIT ? DATA_W'(addr_l) : state == ADDR ? wdata_l : '0;
  assign sshift = state == ADDR || state == WDATA || state == RDATA;

  spi_mem_shifter u_shift (
    .clk(clk), .rst(rst), .load(sload), .shift(sshift), .sin(sdi),
    .din(sdin), .q(sq), .last(slast)
  );

  assign cs_n = state != START;
  assign sdo = state == OPBIT ? we_l : (state == ADDR || state == WDATA) ? sq[0] : 1'b0;
  assign ack = state == ACK ? (gnt ? 2'b10 : 2'b01) : '0;

  // read data updates only on the final RDATA bit; a timeout clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (tmo_hit) rdata <= '0;
    else if (state == RDATA && slast) rdata <= {sdi, sq[DATA_W-1:1]};

`ifdef SPI_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tcnt;
  logic waiting;
  assign waiting = state == WAIT_RDY || state == WAIT_DONE;
  assign tmo_hit = waiting && tcnt == CW'(TIMEOUT_CYC - 1) &&
                   !(state == WAIT_RDY ? mem_ready : mem_op_done);
  // cycles spent in the current wait state
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= waiting ? tcnt + 1'b1 : '0;
  // err is high only in the ACK cycle that a timeout produced
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else err <= tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: randomized directed bench with a serial memory stub and a transaction-level reference model
module tb_spi_mem_arbiter;
  localparam int TO = 64;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, we = 0, ack;
  logic [9:0] addr = 0;
  logic [15:0] wdata = 0;
  logic [7:0] rdata;
  logic err, cs_n, sdo;
  logic sdi = 0, mem_ready = 0, mem_op_done = 0;
  int vectors = 0, miscompares = 0;

  logic [7:0] ref_mem [32] = '{default: 8'h00};
  logic [7:0] smem [32] = '{default: 8'h00};
  int last_g = 1;
  logic [7:0] exp_rd = 0;

  int n = 0, rdy_dly = 0, done_dly = 0, cs_lows = 0;
  bit act = 0, hold_rdy = 0;
  logic op = 0;
  logic [7:0] sa = 0, sd = 0;

  spi_mem_arbiter #(.TIMEOUT_CYC(TO), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .cs_n(cs_n), .sdo(sdo), .sdi(sdi),
    .mem_ready(mem_ready), .mem_op_done(mem_op_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!cs_n) cs_lows++;

  // serial memory stub: frame = op bit, 8 address bits, 8 data bits on write; sdi returns data on read
  always @(negedge clk) begin
    mem_ready = 0;
    mem_op_done = 0;
    sdi = 0;
    if (rst) act = 0;
    else if (!cs_n) begin
      act = 1;
      n = 0;
    end else if (act) begin
      n++;
      if (n == 1) op = sdo;
      else if (n <= 9) sa[n-2] = sdo;
      else if (op) begin
        if (n <= 17) sd[n-10] = sdo;
        else if (n == 18 + done_dly) begin
          smem[sa[4:0]] = sd;
          mem_op_done = 1;
          act = 0;
        end
      end else begin
        if (n == 10 + rdy_dly) mem_ready = !hold_rdy;
        else if (n >= 11 + rdy_dly && n <= 18 + rdy_dly) sdi = smem[sa[4:0]][n-11-rdy_dly];
        else if (n == 19 + rdy_dly + done_dly) begin
          mem_op_done = 1;
          act = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic go(input logic [1:0] r, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                    input logic [7:0] d0, input logic [7:0] d1, input int rd_d, input int dn_d);
    logic [1:0] pend;
    int win, cyc, lat, base;
    bit first, got;
    logic wv;
    logic [4:0] av;
    logic [7:0] dv;
    @(negedge clk);
    pend = r;
    first = 1;
    rdy_dly = rd_d;
    done_dly = dn_d;
    we = w;
    addr = {a1, a0};
    wdata = {d1, d0};
    req = r;
    while (pend != 0) begin
      win = pend == 2'b11 ? 1 - last_g : (pend[1] ? 1 : 0);
      wv = w[win];
      av = win ? a1 : a0;
      dv = win ? d1 : d0;
      lat = wv ? 20 + dn_d : hold_rdy ? 11 + TO : 21 + rd_d + dn_d;
      base = cs_lows;
      cyc = 0;
      got = 0;
      while (!got && cyc < 400) begin
        @(negedge clk);
        cyc++;
        got = ack != 0;
      end
      chk("ack_seen", 32'(got), 1);
      chk("ack_who", 32'(ack), win ? 2 : 1);
      chk("latency", cyc, lat + (first ? 0 : 1));
      chk("cs_low_once", cs_lows - base, 1);
      chk("op_bit", 32'(op), 32'(wv));
      chk("addr_bits", 32'(sa), 32'(av));
      if (wv) begin
        chk("wdata_bits", 32'(sd), 32'(dv));
        ref_mem[av] = dv;
      end else exp_rd = hold_rdy ? 8'h00 : ref_mem[av];
      chk("rdata", 32'(rdata), 32'(exp_rd));
      chk("err", 32'(err), 32'(hold_rdy && !wv));
      req[win] = 1'b0;
      pend[win] = 1'b0;
      last_g = win;
      first = 0;
    end
  endtask

  initial begin
    logic [7:0] nd;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    go(2'b01, 2'b01, 5'h03, 5'h00, 8'hA5, 8'h00, 0, 0);
    go(2'b10, 2'b00, 5'h00, 5'h03, 8'h00, 8'h00, 0, 0);
    repeat (2) go(2'b11, 2'($urandom), 5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
    go(2'b01, 2'b01, 5'h1F, 5'h00, 8'h00, 8'h00, 0, 0);
    go(2'b01, 2'b00, 5'h1F, 5'h00, 8'h00, 8'h00, 0, 0);
    repeat (10) go(2'($urandom_range(1, 3)), 2'($urandom), 5'($urandom), 5'($urandom),
                   8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
`ifdef SPI_MEM_ARB_TIMEOUT_EN
    hold_rdy = 1;
    go(2'b01, 2'b00, 5'h03, 5'h00, 8'h00, 8'h00, 0, 0);
    hold_rdy = 0;
`endif
    go(2'b10, 2'b00, 5'h00, 5'h03, 8'h00, 8'h00, 1, 0);
    @(negedge clk);
    we = 2'b01;
    addr = {5'h00, 5'h0A};
    wdata = {8'h00, ~ref_mem[5'h0A]};
    req = 2'b01;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_cs_n", 32'(cs_n), 1);
    chk("mid_rst_sdo", 32'(sdo), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_in_rst", 32'(ack), 0);
    end
    rst = 0;
    last_g = 1;
    exp_rd = 0;
    go(2'b01, 2'b00, 5'h0A, 5'h00, 8'h00, 8'h00, 0, 0);
    nd = 8'($urandom);
    go(2'b10, 2'b10, 5'h00, 5'h0A, 8'h00, nd, 0, 1);
    go(2'b01, 2'b00, 5'h0A, 5'h00, 8'h00, 8'h00, 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
